mem_access_ctrl: RTL

Data-memory access sequencer for the execute/writeback/memory stage of the Minos pipeline. It accepts one load or store per instruction from the stage and drives a single-outstanding valid/ack data bus. It holds the pipeline with `Stall` until the access completes, then returns lane-aligned, size-extended load data. It also computes byte write strobes, detects misaligned accesses and times out a non-responding bus.

---
 rtl/mem_access_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: data-memory access sequencer for the Minos pipeline.
// Single-outstanding valid/ack bus, lane steering, load extension, timeout.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        ReqValid,
    input  logic        ReqWE,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [1:0]  ReqWHBS,
    input  logic        ReqLS,
    output logic        Stall,
    output logic        BusReq,
    output logic        BusWE,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusStrb,
    input  logic        BusAck,
    input  logic [31:0] BusRData,
    output logic        LdValid,
    output logic [31:0] LdData,
    output logic        MisAlign,
    output logic        BusErr
);
    typedef enum logic [1:0] { IDLE, BUSY, DONE, ERR } state_e;

    localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYC);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q;
    logic [1:0]  sz_q;
    logic        ls_q, we_q;

    logic        is_word, is_half, is_byte;
    logic        mis, accept, ack_busy, to_hit;
    logic [3:0]  req_strb;
    logic [31:0] req_wdata;
    logic [31:0] rd_sh, ld_ext;

    logic        busreq_q, busreq_d;
    logic        buswe_q, buswe_d;
    logic [31:0] busaddr_q, busaddr_d;
    logic [31:0] buswdata_q, buswdata_d;
    logic [3:0]  busstrb_q, busstrb_d;
    logic        ldvalid_q, ldvalid_d;
    logic [31:0] lddata_q, lddata_d;
    logic        misalign_q, misalign_d;
    logic        buserr_q, buserr_d;

    assign is_word  = ReqWHBS[1];
    assign is_half  = ~ReqWHBS[1] & ReqWHBS[0];
    assign is_byte  = ~ReqWHBS[1] & ~ReqWHBS[0];
    assign mis      = is_word ? (|ReqAddr[1:0]) : (is_half & ReqAddr[0]);
    assign accept   = (state_q == IDLE) & ReqValid;
    assign ack_busy = (state_q == BUSY) & BusAck;
    assign to_hit   = (TO_LIM != 9'd0) & (({1'b0, cnt_q} + 9'd1) == TO_LIM);

    // Stall is the only combinational output; reset drops it at once
    assign Stall = rst_n & (((state_q == IDLE) & ReqValid) | (state_q == BUSY));

    assign BusReq   = busreq_q;
    assign BusWE    = buswe_q;
    assign BusAddr  = busaddr_q;
    assign BusWData = buswdata_q;
    assign BusStrb  = busstrb_q;
    assign LdValid  = ldvalid_q;
    assign LdData   = lddata_q;
    assign MisAlign = misalign_q;
    assign BusErr   = buserr_q;

    // state register and BUSY-cycle timeout counter
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state decision; ack in the timeout cycle takes priority
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (ReqValid) state_d = mis ? ERR : BUSY;
            BUSY: begin
                if (BusAck)      state_d = DONE;
                else if (to_hit) state_d = ERR;
            end
            DONE: state_d = IDLE;
            ERR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // count unacknowledged BUSY cycles, cleared on each new request
    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = '0;
        else if ((state_q == BUSY) && !BusAck)
            cnt_d = cnt_q + 8'd1;
    end

    // keep request attributes needed while the access is in flight
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= '0;
            sz_q  <= '0;
            ls_q  <= 1'b0;
            we_q  <= 1'b0;
        end else if (accept) begin
            off_q <= ReqAddr[1:0];
            sz_q  <= {is_word, is_half};
            ls_q  <= ReqLS;
            we_q  <= ReqWE;
        end
    end

    // byte-lane strobes and replicated store data for the incoming request
    always_comb begin
        req_strb  = 4'b0000;
        req_wdata = ReqWData;
        unique case (1'b1)
            is_word: begin
                req_strb  = 4'b1111;
                req_wdata = ReqWData;
            end
            is_half: begin
                req_strb  = ReqAddr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{ReqWData[15:0]}};
            end
            is_byte: begin
                req_strb  = 4'b0001 << ReqAddr[1:0];
                req_wdata = {4{ReqWData[7:0]}};
            end
            default: ;
        endcase
    end

    assign rd_sh = BusRData >> {off_q, 3'b000};

    // pick the addressed lane of the read data and extend it
    always_comb begin
        ld_ext = BusRData;
        unique case (1'b1)
            sz_q[1]: ld_ext = BusRData;
            sz_q[0]: ld_ext = {{16{ls_q & rd_sh[15]}}, rd_sh[15:0]};
            default: ld_ext = {{24{ls_q & rd_sh[7]}}, rd_sh[7:0]};
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        busreq_d   = (state_d == BUSY);
        buswe_d    = busreq_d & ((state_q == IDLE) ? ReqWE : we_q);
        busaddr_d  = busaddr_q;
        buswdata_d = buswdata_q;
        busstrb_d  = busstrb_q;
        if (accept && !mis) begin
            busaddr_d  = {ReqAddr[31:2], 2'b00};
            buswdata_d = req_wdata;
            busstrb_d  = req_strb;
        end
        ldvalid_d  = ack_busy & ~we_q;
        lddata_d   = ldvalid_d ? ld_ext : lddata_q;
        misalign_d = accept & mis;
        buserr_d   = (state_q == BUSY) & ~BusAck & to_hit;
    end

    // registered output stage
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            busreq_q   <= 1'b0;
            buswe_q    <= 1'b0;
            busaddr_q  <= '0;
            buswdata_q <= '0;
            busstrb_q  <= '0;
            ldvalid_q  <= 1'b0;
            lddata_q   <= '0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            busreq_q   <= busreq_d;
            buswe_q    <= buswe_d;
            busaddr_q  <= busaddr_d;
            buswdata_q <= buswdata_d;
            busstrb_q  <= busstrb_d;
            ldvalid_q  <= ldvalid_d;
            lddata_q   <= lddata_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

endmodule
